// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier.
// Contents: state encoding, datapath widths, last-iteration count, magnitude helper.
package mul_pkg;

    localparam int unsigned MUL_W = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [CNT_W-1:0] MUL_CNT_LAST = CNT_W'(31);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        NEG  = 2'd3
    } mul_state_e;

    // Two's complement magnitude; 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [MUL_W-1:0] abs_val(input logic [MUL_W-1:0] x);
        return x[MUL_W-1] ? (~x + MUL_W'(1)) : x;
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit adder with carry in/out used as the multiplier accumulate and increment unit.
// Ports: a, b (32b operands), c_in (carry in), sum (32b result), c_out (carry out).
module adder_32bit
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             c_in,
    output logic [MUL_W-1:0] sum,
    output logic             c_out
);

    // 33-bit result keeps the carry so no overflow is ever lost.
    always_comb begin
        {c_out, sum} = (MUL_W+1)'(a) + (MUL_W+1)'(b) + (MUL_W+1)'(c_in);
    end

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Iterative 32x32->64 shift-and-add multiplier, one multiplier bit per clock.
// Ports: clk, rst_n (sync active-low), in1/in2 (operands, sampled on accepted start),
//        start (accepted in IDLE only), busy, done (1-cycle pulse), product (64b, held).
// Optional: SIGNED_MUL_EN selects two's complement operands and adds a two-cycle NEG state.
module seq_multiplier_32bit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mul_state_e       state, state_nxt;
    logic [MUL_W-1:0] mcand, mcand_nxt;
    logic [MUL_W-1:0] acc_hi, acc_hi_nxt;
    logic [MUL_W-1:0] acc_lo, acc_lo_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt;
    logic [2*MUL_W-1:0] product_nxt;

    logic [MUL_W-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

`ifdef SIGNED_MUL_EN
    logic neg, neg_nxt;
    logic neg_carry, neg_carry_nxt;
    logic neg_phase, neg_phase_nxt;
`endif

    adder_32bit u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
`ifdef SIGNED_MUL_EN
            neg       <= 1'b0;
            neg_carry <= 1'b0;
            neg_phase <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            mcand   <= mcand_nxt;
            acc_hi  <= acc_hi_nxt;
            acc_lo  <= acc_lo_nxt;
            cnt     <= cnt_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            product <= product_nxt;
`ifdef SIGNED_MUL_EN
            neg       <= neg_nxt;
            neg_carry <= neg_carry_nxt;
            neg_phase <= neg_phase_nxt;
`endif
        end
    end

    // Next-state, datapath and adder operand selection.
    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        acc_hi_nxt  = acc_hi;
        acc_lo_nxt  = acc_lo;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        product_nxt = product;
        add_a       = acc_hi;
        add_b       = mcand;
        add_cin     = 1'b0;
`ifdef SIGNED_MUL_EN
        neg_nxt       = neg;
        neg_carry_nxt = neg_carry;
        neg_phase_nxt = neg_phase;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    acc_hi_nxt = '0;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
`ifdef SIGNED_MUL_EN
                    mcand_nxt  = abs_val(in1);
                    acc_lo_nxt = abs_val(in2);
                    neg_nxt    = in1[MUL_W-1] ^ in2[MUL_W-1];
`else
                    mcand_nxt  = in1;
                    acc_lo_nxt = in2;
`endif
                end
            end

            RUN: begin
                // Add the multiplicand when the current multiplier bit is set, then shift right.
                if (acc_lo[0]) begin
                    {acc_hi_nxt, acc_lo_nxt} = {add_cout, add_sum, acc_lo[MUL_W-1:1]};
                end else begin
                    {acc_hi_nxt, acc_lo_nxt} = {1'b0, acc_hi, acc_lo[MUL_W-1:1]};
                end
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == MUL_CNT_LAST) begin
`ifdef SIGNED_MUL_EN
                    state_nxt     = NEG;
                    neg_phase_nxt = 1'b0;
`else
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    product_nxt = {acc_hi_nxt, acc_lo_nxt};
`endif
                end
            end

`ifdef SIGNED_MUL_EN
            // Two-cycle negate: low half ~x+1 first, then high half ~x+carry.
            NEG: begin
                add_b = '0;
                if (!neg_phase) begin
                    add_a         = ~acc_lo;
                    add_cin       = 1'b1;
                    neg_phase_nxt = 1'b1;
                    if (neg) begin
                        acc_lo_nxt    = add_sum;
                        neg_carry_nxt = add_cout;
                    end
                end else begin
                    add_a       = ~acc_hi;
                    add_cin     = neg_carry;
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    if (neg) begin
                        acc_hi_nxt  = add_sum;
                        product_nxt = {add_sum, acc_lo};
                    end else begin
                        product_nxt = {acc_hi, acc_lo};
                    end
                end
            end
`endif

            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed self-checking bench for seq_multiplier_32bit (unsigned or SIGNED_MUL_EN builds).
module tb_seq_multiplier_32bit;

`ifdef SIGNED_MUL_EN
    localparam int LAT = 35;
    localparam logic [63:0] EXP_MAX = 64'h0000_0000_0000_0001;
    localparam logic [63:0] EXP_B2B = 64'hFFFF_FFFF_0000_0000;
`else
    localparam int LAT = 33;
    localparam logic [63:0] EXP_MAX = 64'hFFFF_FFFE_0000_0001;
    localparam logic [63:0] EXP_B2B = 64'h0000_0001_0000_0000;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        start;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks;
    int errors;

    seq_multiplier_32bit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (in1),
        .in2     (in2),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for one edge; returns at the negedge after acceptance.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges (starting at 1 right after acceptance) until done is seen; -1 on timeout.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        in1 = '0;
        in2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (product !== 64'h0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        launch(32'd3, 32'd5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", busy); end
        wait_done(n);
        checks++;
        if (n != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", n, LAT); end
        checks++;
        if (product !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_product: got %h expected %h", product, 64'hF); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++;
        if (product !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_product_hold: got %h expected %h", product, 64'hF); end
        @(negedge clk);
    endtask

    task automatic test_max;
        int n;
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        checks++;
        if (product !== EXP_MAX) begin errors++; $display("FAIL max_product: got %h expected %h", product, EXP_MAX); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        in1   = 32'h0;
        in2   = 32'h1234_5678;
        start = 1'b1;
        @(negedge clk);
        wait_done(n);
        checks++;
        if (product !== 64'h0) begin errors++; $display("FAIL b2b_first_product: got %h expected 0", product); end
        in1 = 32'h8000_0000;
        in2 = 32'd2;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b expected 0", busy); end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy %b expected 1", busy); end
        wait_done(n);
        checks++;
        if (n != LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", n, LAT); end
        checks++;
        if (product !== EXP_B2B) begin errors++; $display("FAIL b2b_second_product: got %h expected %h", product, EXP_B2B); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int pulses;
        int first;
        logic [63:0] seen;
        pulses = 0;
        first  = -1;
        seen   = '0;
        launch(32'h0000_1234, 32'h0000_0010);
        for (int i = 1; i <= 80; i++) begin
            if (i == 10) begin
                in1   = 32'h0000_FFFF;
                in2   = 32'h0000_FFFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    seen  = product;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", pulses); end
        checks++;
        if (first != LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", first, LAT); end
        checks++;
        if (seen !== 64'h0000_0000_0001_2340) begin errors++; $display("FAIL ignore_product: got %h expected %h", seen, 64'h12340); end
    endtask

    task automatic test_reset_mid;
        int n;
        int pulses;
        launch(32'h0000_DEAD, 32'h0000_BEEF);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++;
        if (product !== 64'h0) begin errors++; $display("FAIL midrst_product: got %h expected 0", product); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
        launch(32'd7, 32'd9);
        wait_done(n);
        checks++;
        if (n != LAT) begin errors++; $display("FAIL midrst_fresh_latency: got %0d expected %0d", n, LAT); end
        checks++;
        if (product !== 64'd63) begin errors++; $display("FAIL midrst_fresh_product: got %h expected %h", product, 64'd63); end
        repeat (2) @(negedge clk);
    endtask

`ifdef SIGNED_MUL_EN
    task automatic test_signed;
        int n;
        launch(32'hFFFF_FFFD, 32'd7);
        wait_done(n);
        checks++;
        if (n != 35) begin errors++; $display("FAIL signed_latency: got %0d expected 35", n); end
        checks++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL signed_neg3x7: got %h expected %h", product, 64'hFFFF_FFFF_FFFF_FFEB); end
        repeat (2) @(negedge clk);
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        checks++;
        if (product !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL signed_minint: got %h expected %h", product, 64'h8000_0000); end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
`ifdef SIGNED_MUL_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
